// File: rtl/irrig_pkg.sv
// Shared types for the multi-channel irrigation controller.
package irrig_pkg;

  // Channel state encoding, as it appears on cout.
  typedef enum logic [1:0] {
    VZ   = 2'b00,
    EN   = 2'b01,
    ERRO = 2'b10,
    REGA = 2'b11
  } state_t;

endpackage

// File: rtl/irrig_chan.sv
// One irrigation channel: four-state FSM, ERRO debounce counter and pump request.
module irrig_chan
  import irrig_pkg::*;
#(
  parameter int unsigned ERR_HOLD = 4
) (
  input  logic   clock,
  input  logic   resetN,
  input  logic   c,
  input  logic   ve,
  input  logic   rega,
  input  logic   gnt,
  input  logic   timeout,
  output logic   req,
  output state_t state
);

  localparam int unsigned HW = (ERR_HOLD > 1) ? $clog2(ERR_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(ERR_HOLD - 1);

  state_t         r_state;
  logic [HW-1:0]  r_hold;
  logic           w_release;

  assign state     = r_state;
  assign w_release = ~rega && (r_hold == HOLD_MAX);

  // Pump request: EN wanting to water, or a released ERRO that wants to water.
  always_comb begin
    req = 1'b0;
    case (r_state)
      EN:      req = c & ~ve;
      ERRO:    req = w_release & c & ~ve;
      default: req = 1'b0;
    endcase
  end

  // Channel FSM and debounce counter; the counter clears on every ERRO entry.
  always_ff @(posedge clock or posedge resetN) begin
    if (resetN) begin
      r_state <= VZ;
      r_hold  <= '0;
    end else begin
      case (r_state)
        VZ: begin
          if (~c & ve & ~rega) begin
            r_state <= EN;
          end else if (rega) begin
            r_state <= ERRO;
            r_hold  <= '0;
          end
        end
        EN: begin
          if (c & ~ve) begin
            if (gnt) r_state <= REGA;
          end else if (ve & rega) begin
            r_state <= ERRO;
            r_hold  <= '0;
          end
        end
        REGA: begin
          if (timeout) begin
            r_state <= ERRO;
            r_hold  <= '0;
          end else if (c & ve & ~rega) begin
            r_state <= EN;
          end else if (~c & ~rega) begin
            r_state <= VZ;
          end
        end
        ERRO: begin
          if (rega) begin
            r_hold <= '0;
          end else if (r_hold != HOLD_MAX) begin
            r_hold <= r_hold + 1'b1;
          end else if (~c & ~ve) begin
            r_state <= VZ;
          end else if (ve) begin
            r_state <= EN;
          end else if (gnt) begin
            // c & ~ve: wait here with the counter saturated until the pump is free
            r_state <= REGA;
          end
        end
        default: r_state <= VZ;
      endcase
    end
  end

endmodule

// File: rtl/irrig_ctrl_multi.sv
// Multi-channel irrigation controller: N_CH channels sharing one pump via round-robin.
module irrig_ctrl_multi
  import irrig_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned TMR_W      = 8,
  parameter int unsigned REGA_TICKS = 16,
  parameter int unsigned ERR_HOLD   = 4
) (
  input  logic                      clock,
  input  logic                      resetN,
  input  logic                      tick,
  input  logic [N_CH-1:0]           c,
  input  logic [N_CH-1:0]           ve,
  input  logic [N_CH-1:0]           rega,
  output logic [2*N_CH-1:0]         cout,
  output logic                      pump_on,
  output logic [$clog2(N_CH)-1:0]   active_ch,
  output logic                      err_any
);

  localparam int unsigned IDX_W = $clog2(N_CH);

  state_t             w_state [N_CH];
  logic [N_CH-1:0]    w_req;
  logic [N_CH-1:0]    w_gnt;
  logic               w_found;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic               w_any_rega;
  logic               w_timeout;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [TMR_W-1:0]   r_tmr;

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    irrig_chan #(
      .ERR_HOLD(ERR_HOLD)
    ) u_chan (
      .clock  (clock),
      .resetN (resetN),
      .c      (c[g]),
      .ve     (ve[g]),
      .rega   (rega[g]),
      .gnt    (w_gnt[g]),
      .timeout(w_timeout),
      .req    (w_req[g]),
      .state  (w_state[g])
    );
  end

  // Output decode from registered channel state only.
  always_comb begin
    cout       = '0;
    w_any_rega = 1'b0;
    active_ch  = '0;
    err_any    = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      cout[2*i +: 2] = w_state[i];
      if (w_state[i] == REGA) begin
        w_any_rega = 1'b1;
        active_ch  = IDX_W'(i);
      end
      if (w_state[i] == ERRO) err_any = 1'b1;
    end
  end

  assign pump_on   = w_any_rega;
  assign w_timeout = tick & w_any_rega & (r_tmr == TMR_W'(REGA_TICKS - 1));

  // Round-robin grant, only while the pump is idle, scanning upward from r_rr_ptr.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    w_gnt     = '0;
    w_found   = 1'b0;
    w_gnt_idx = '0;
    if (!w_any_rega) begin
      for (int k = 0; k < N_CH; k++) begin
        idx = (int'(r_rr_ptr) + k) % N_CH;
        if (!w_found && w_req[IDX_W'(idx)]) begin
          w_found              = 1'b1;
          w_gnt[IDX_W'(idx)]   = 1'b1;
          w_gnt_idx            = IDX_W'(idx);
        end
      end
    end
  end

  // Pointer moves just past the granted channel.
  always_ff @(posedge clock or posedge resetN) begin
    if (resetN) begin
      r_rr_ptr <= '0;
    end else if (w_found) begin
      r_rr_ptr <= (w_gnt_idx == IDX_W'(N_CH - 1)) ? '0 : w_gnt_idx + 1'b1;
    end
  end

  // Watering timer: cleared on entry and while idle, so an entry-cycle tick is ignored.
  always_ff @(posedge clock or posedge resetN) begin
    if (resetN) begin
      r_tmr <= '0;
    end else if (!w_any_rega || w_found) begin
      r_tmr <= '0;
    end else if (tick) begin
      r_tmr <= r_tmr + 1'b1;
    end
  end

endmodule

// File: tb/tb_irrig_ctrl_multi.sv
// Directed bench for irrig_ctrl_multi (N_CH=4, REGA_TICKS=3, ERR_HOLD=4).
module tb_irrig_ctrl_multi;

  logic       clock = 1'b0;
  logic       resetN;
  logic       tick;
  logic [3:0] c, ve, rega;
  logic [7:0] cout;
  logic       pump_on;
  logic [1:0] active_ch;
  logic       err_any;

  int n_checks = 0;
  int n_errors = 0;

  irrig_ctrl_multi #(
    .N_CH      (4),
    .TMR_W     (8),
    .REGA_TICKS(3),
    .ERR_HOLD  (4)
  ) dut (
    .clock    (clock),
    .resetN   (resetN),
    .tick     (tick),
    .c        (c),
    .ve       (ve),
    .rega     (rega),
    .cout     (cout),
    .pump_on  (pump_on),
    .active_ch(active_ch),
    .err_any  (err_any)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    // Reset with random sensor activity
    resetN = 1'b1;
    tick   = 1'b0;
    c      = 4'($urandom);
    ve     = 4'($urandom);
    rega   = 4'($urandom);
    step(3);
    check_eq("rst_cout", 32'(cout), 32'h00);
    check_eq("rst_pump", 32'(pump_on), 32'h0);
    check_eq("rst_act", 32'(active_ch), 32'h0);
    check_eq("rst_err", 32'(err_any), 32'h0);

    c = 4'b0; ve = 4'b0; rega = 4'b0;
    resetN = 1'b0;
    step(3);
    check_eq("idle_vz", 32'(cout), 32'h00);

    // ch0: VZ -> EN -> REGA
    ve[0] = 1'b1;
    step(1);
    check_eq("ch0_en", 32'(cout), 32'b00_00_00_01);
    c[0] = 1'b1; ve[0] = 1'b0;
    step(1);
    check_eq("ch0_rega", 32'(cout), 32'b00_00_00_11);
    check_eq("ch0_pump", 32'(pump_on), 32'h1);
    check_eq("ch0_act", 32'(active_ch), 32'h0);

    // Timeout after three ticks
    tick = 1'b1; step(1); tick = 1'b0;
    tick = 1'b1; step(1); tick = 1'b0;
    check_eq("to_hold", 32'(cout), 32'b00_00_00_11);
    check_eq("to_tmr2", 32'(dut.r_tmr), 32'd2);
    tick = 1'b1; step(1); tick = 1'b0;
    check_eq("to_erro", 32'(cout), 32'b00_00_00_10);
    check_eq("to_pump", 32'(pump_on), 32'h0);
    check_eq("to_err", 32'(err_any), 32'h1);

    // Debounce: rega 0,0,1,0,0,0,0 with ve=1
    c[0] = 1'b0; ve[0] = 1'b1;
    rega[0] = 1'b0; step(1);
    rega[0] = 1'b0; step(1);
    rega[0] = 1'b1; step(1);
    check_eq("db_mid", 32'(cout), 32'b00_00_00_10);
    rega[0] = 1'b0; step(3);
    check_eq("db_3zero", 32'(cout), 32'b00_00_00_10);
    step(1);
    check_eq("db_exit", 32'(cout), 32'b00_00_00_01);
    check_eq("db_err", 32'(err_any), 32'h0);

    // Contention: ch1 and ch2 in EN, both request together
    ve[1] = 1'b1; ve[2] = 1'b1;
    step(1);
    check_eq("ct_en", 32'(cout), 32'b00_01_01_01);
    c[1] = 1'b1; c[2] = 1'b1; ve[1] = 1'b0; ve[2] = 1'b0;
    step(1);
    check_eq("ct_gnt1", 32'(cout), 32'b00_01_11_01);
    check_eq("ct_act1", 32'(active_ch), 32'h1);
    step(1);
    check_eq("ct_wait", 32'(cout), 32'b00_01_11_01);
    c[1] = 1'b0;
    step(1);
    check_eq("ct_exit", 32'(cout), 32'b00_01_00_01);
    check_eq("ct_pfree", 32'(pump_on), 32'h0);
    step(1);
    check_eq("ct_gnt2", 32'(cout), 32'b00_11_00_01);
    check_eq("ct_act2", 32'(active_ch), 32'h2);
    check_eq("ct_pump2", 32'(pump_on), 32'h1);

    // Reset during REGA with tmr=2
    tick = 1'b1; step(1); tick = 1'b0;
    tick = 1'b1; step(1); tick = 1'b0;
    check_eq("rr_tmr2", 32'(dut.r_tmr), 32'd2);
    resetN = 1'b1;
    #1;
    check_eq("ar_cout", 32'(cout), 32'h00);
    check_eq("ar_pump", 32'(pump_on), 32'h0);
    step(1);
    check_eq("ar_tmr", 32'(dut.r_tmr), 32'd0);
    check_eq("ar_ptr", 32'(dut.r_rr_ptr), 32'd0);
    check_eq("ar_act", 32'(active_ch), 32'h0);

    // VZ -> ERRO on rega
    c = 4'b0; ve = 4'b0; rega = 4'b0;
    resetN = 1'b0;
    step(1);
    rega[3] = 1'b1;
    step(1);
    check_eq("vz_erro", 32'(cout), 32'b10_00_00_00);
    check_eq("vz_err", 32'(err_any), 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
